// File: rtl/video_pattern_gen.sv
// Test-pattern source for the HDMI transmitter: renders one registered RGB
// pixel per clk_pixel from the transmitter's (cx,cy), switching modes only at frame start.
module video_pattern_gen #(
  parameter int          BIT_WIDTH   = 11,
  parameter int          BIT_HEIGHT  = 10,
  parameter logic [23:0] SOLID_COLOR = 24'hFF0000,
  parameter int          CHECK_LOG2  = 5,
  parameter int          BAR_WIDTH   = 16,
  parameter int          BAR_SPEED   = 4
) (
  input  logic                  clk_pixel,
  input  logic                  sys_resetn,
  input  logic [2:0]            mode,
  input  logic [BIT_WIDTH-1:0]  cx,
  input  logic [BIT_HEIGHT-1:0] cy,
  input  logic [BIT_WIDTH-1:0]  screen_width,
  input  logic [BIT_HEIGHT-1:0] screen_height,
  output logic [23:0]           rgb,
  output logic                  frame_start,
  output logic [7:0]            frame_count
);

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [BIT_WIDTH:0]    BAR_SPEED_W = (BIT_WIDTH+1)'(BAR_SPEED);
  localparam logic [BIT_WIDTH:0]    BAR_WIDTH_W = (BIT_WIDTH+1)'(BAR_WIDTH);
  localparam logic [BIT_WIDTH-1:0]  ONE_X       = BIT_WIDTH'(1'b1);
  localparam logic [BIT_HEIGHT-1:0] ONE_Y       = BIT_HEIGHT'(1'b1);

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  logic [2:0]           mode_r;
  logic [BIT_WIDTH-1:0] bar_x_r;
  logic [23:0]          rgb_r;
  logic                 frame_start_r;
  logic [7:0]           frame_count_r;

  logic                 fs_s;
  logic [2:0]           mode_eff_s;
  logic [BIT_WIDTH:0]   bar_sum_s;
  logic [BIT_WIDTH:0]   bar_end_s;
  logic [BIT_WIDTH-1:0] bar_next_s;
  logic                 in_bar_s;
  logic [BIT_WIDTH-1:0] bar_w_s;
  logic [2:0]           idx_s;
  logic                 border_s;
  logic                 blank_s;
  logic [23:0]          pix_s;

  // The (0,0) pixel already uses the mode sampled on its own edge.
  assign fs_s       = (cx == '0) && (cy == '0);
  assign mode_eff_s = fs_s ? mode : mode_r;
  assign bar_sum_s  = {1'b0, bar_x_r} + BAR_SPEED_W;
  assign bar_next_s = (bar_sum_s < {1'b0, screen_width}) ? bar_sum_s[BIT_WIDTH-1:0] : '0;
  assign bar_end_s  = {1'b0, bar_x_r} + BAR_WIDTH_W;
  assign in_bar_s   = (cx >= bar_x_r) && ({1'b0, cx} < bar_end_s);
  assign bar_w_s    = screen_width >> 3;
  assign border_s   = (cx == '0) || (cy == '0) ||
                      (cx == screen_width - ONE_X) || (cy == screen_height - ONE_Y);
  assign blank_s    = (cx >= screen_width) || (cy >= screen_height);

  // Colour-bar index: count how many of the seven bar boundaries cx has passed.
  always_comb begin
    logic [BIT_WIDTH+2:0] thr_s;
    thr_s = '0;
    idx_s = 3'd0;
    for (int k = 0; k < 7; k++) begin
      thr_s = thr_s + {3'b000, bar_w_s};
      if ({3'b000, cx} >= thr_s) idx_s = idx_s + 3'd1;
      else                       idx_s = idx_s;
    end
  end

  // Pattern select for the current coordinate.
  always_comb begin
    pix_s = BLACK;
    if (blank_s) begin
      pix_s = BLACK;
    end else begin
      case (mode_eff_s)
        3'd0:    pix_s = SOLID_COLOR;
        3'd1:    pix_s = bar_colour(idx_s);
        3'd2:    pix_s = (cx[CHECK_LOG2] ^ cy[CHECK_LOG2]) ? WHITE : BLACK;
        3'd3:    pix_s = {3{cx[7:0]}};
        3'd4:    pix_s = in_bar_s ? WHITE : BLUE;
        3'd5:    pix_s = border_s ? WHITE : BLACK;
        default: pix_s = BLACK;
      endcase
    end
  end

  // Output pixel register plus per-frame state (mode, bar position, frame counter).
  always_ff @(posedge clk_pixel or negedge sys_resetn) begin
    if (!sys_resetn) begin
      rgb_r         <= 24'h000000;
      frame_start_r <= 1'b0;
      frame_count_r <= 8'd0;
      mode_r        <= 3'd0;
      bar_x_r       <= '0;
    end else begin
      rgb_r         <= pix_s;
      frame_start_r <= fs_s;
      if (fs_s) begin
        mode_r        <= mode;
        frame_count_r <= frame_count_r + 8'd1;
        bar_x_r       <= bar_next_s;
      end else begin
        mode_r        <= mode_r;
        frame_count_r <= frame_count_r;
        bar_x_r       <= bar_x_r;
      end
    end
  end

  assign rgb         = rgb_r;
  assign frame_start = frame_start_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen: per-cycle comparison against an
// arithmetic pixel model, plus hand-computed spot values.
module tb_video_pattern_gen;

  localparam int SW = 1280;
  localparam int SH = 720;

  logic        clk_pixel = 1'b0;
  logic        sys_resetn;
  logic [2:0]  mode;
  logic [10:0] cx;
  logic [9:0]  cy;
  logic [10:0] screen_width;
  logic [9:0]  screen_height;
  logic [23:0] rgb;
  logic        frame_start;
  logic [7:0]  frame_count;

  int total  = 0;
  int passed = 0;
  bit check_en = 1'b0;

  video_pattern_gen dut (
    .clk_pixel     (clk_pixel),
    .sys_resetn    (sys_resetn),
    .mode          (mode),
    .cx            (cx),
    .cy            (cy),
    .screen_width  (screen_width),
    .screen_height (screen_height),
    .rgb           (rgb),
    .frame_start   (frame_start),
    .frame_count   (frame_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passed++;
  endtask

  function automatic logic [23:0] bars_tbl(input int idx);
    case (idx)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] model_pix(input int m, input int x, input int y, input int bar);
    int idx;
    logic [7:0] g;
    if (x >= SW || y >= SH) return 24'h000000;
    case (m)
      0: return 24'hFF0000;
      1: begin
        idx = x / (SW / 8);
        if (idx > 7) idx = 7;
        return bars_tbl(idx);
      end
      2: return ((((x / 32) + (y / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      3: begin
        g = 8'(x % 256);
        return {g, g, g};
      end
      4: return (x >= bar && x < bar + 16) ? 24'hFFFFFF : 24'h0000FF;
      5: return (x == 0 || y == 0 || x == SW - 1 || y == SH - 1) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  int          m_mode = 0;
  int          m_bar  = 0;
  int          m_fc   = 0;
  logic [23:0] exp_rgb = 24'h0;
  logic        exp_fs  = 1'b0;

  // Reference model: frame-level state and the expected registered outputs.
  always @(posedge clk_pixel or negedge sys_resetn) begin
    int  nm;
    bit  fs;
    if (!sys_resetn) begin
      m_mode  <= 0;
      m_bar   <= 0;
      m_fc    <= 0;
      exp_rgb <= 24'h0;
      exp_fs  <= 1'b0;
    end else begin
      fs = (cx == 11'd0) && (cy == 10'd0);
      nm = fs ? int'(mode) : m_mode;
      m_mode  <= nm;
      m_fc    <= fs ? (m_fc + 1) % 256 : m_fc;
      exp_rgb <= model_pix(nm, int'(cx), int'(cy), m_bar);
      exp_fs  <= fs;
      m_bar   <= fs ? ((m_bar + 4 < SW) ? m_bar + 4 : 0) : m_bar;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_pixel) begin
    if (check_en) begin
      chk("rgb", rgb, exp_rgb);
      chk("frame_start", {23'h0, frame_start}, {23'h0, exp_fs});
      chk("frame_count", {16'h0, frame_count}, 24'(m_fc));
    end
  end

  task automatic px(input int x, input int y);
    cx = 11'(x);
    cy = 10'(y);
    @(posedge clk_pixel);
    #1;
  endtask

  int bx_list [6] = '{0, 159, 160, 1119, 1120, 1279};
  logic [23:0] bc_list [6] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h0000FF, 24'h000000, 24'h000000};

  initial begin
    int b;
    sys_resetn    = 1'b1;
    mode          = 3'd0;
    cx            = 11'd5;
    cy            = 10'd5;
    screen_width  = 11'd1280;
    screen_height = 10'd720;
    #1 sys_resetn = 1'b0;
    check_en = 1'b1;
    repeat (3) @(posedge clk_pixel);
    #1;
    chk("reset_rgb", rgb, 24'h0);
    chk("reset_fc", {16'h0, frame_count}, 24'h0);
    sys_resetn = 1'b1;

    // Solid raster with horizontal blanking
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 1650; x++) begin
        px(x, y);
        if (x == 0 && y == 0) begin
          chk("first_fs", {23'h0, frame_start}, 24'h1);
          chk("first_fc", {16'h0, frame_count}, 24'h1);
        end
        if (x == 100) chk("solid_active", rgb, 24'hFF0000);
        if (x == 1280) chk("solid_hblank", rgb, 24'h0);
        if (x == 1649) chk("solid_hblank_end", rgb, 24'h0);
      end
    end
    for (int x = 0; x < 10; x++) px(x, 720);
    chk("solid_vblank", rgb, 24'h0);

    // Colour bars
    mode = 3'd1;
    px(0, 0);
    for (int i = 0; i < 6; i++) begin
      px(bx_list[i], 10);
      chk("colour_bars", rgb, bc_list[i]);
    end

    // Checkerboard
    mode = 3'd2;
    px(0, 0);
    chk("check_0_0", rgb, 24'h000000);
    px(32, 0);
    chk("check_32_0", rgb, 24'hFFFFFF);
    px(32, 32);
    chk("check_32_32", rgb, 24'h000000);
    px(31, 33);
    chk("check_31_33", rgb, 24'hFFFFFF);

    // Gradient
    mode = 3'd3;
    px(0, 0);
    px(300, 5);
    chk("gradient_300", rgb, 24'h2C2C2C);

    // Frame-synchronous switch 0 -> 5
    mode = 3'd0;
    px(0, 0);
    px(639, 360);
    mode = 3'd5;
    px(640, 360);
    chk("midframe_640", rgb, 24'hFF0000);
    px(641, 360);
    chk("midframe_641", rgb, 24'hFF0000);
    px(0, 0);
    chk("switch_rgb", rgb, 24'hFFFFFF);
    chk("switch_fs", {23'h0, frame_start}, 24'h1);
    chk("switch_fc", {16'h0, frame_count}, 24'h6);
    px(1, 0);
    chk("switch_fs_drop", {23'h0, frame_start}, 24'h0);
    px(5, 5);
    chk("border_inner", rgb, 24'h0);
    px(1279, 5);
    chk("border_right", rgb, 24'hFFFFFF);

    // frame_count wrap over 256 frames
    for (int i = 0; i < 256; i++) begin
      px(0, 0);
      if (i == 248) chk("fc_255", {16'h0, frame_count}, 24'd255);
      if (i == 249) chk("fc_wrap", {16'h0, frame_count}, 24'd0);
      px(3, 3);
    end
    chk("fc_after_256", {16'h0, frame_count}, 24'h6);

    // Moving bar from reset
    #2 sys_resetn = 1'b0;
    #1 sys_resetn = 1'b1;
    mode = 3'd4;
    for (int n = 1; n <= 321; n++) begin
      px(0, 0);
      if (n == 1) chk("bar_first_00", rgb, 24'hFFFFFF);
      b = (4 * n) % 1280;
      px(b, 1);
      chk("bar_pos", rgb, 24'hFFFFFF);
      if (n == 319) begin
        for (int x = 1277; x < 1280; x++) begin
          px(x, 1);
          chk("bar_edge", rgb, 24'hFFFFFF);
        end
        px(0, 1);
        chk("bar_edge_x0", rgb, 24'h0000FF);
      end
    end

    // Asynchronous reset mid-line with bar_x=100
    #2 sys_resetn = 1'b0;
    #1 sys_resetn = 1'b1;
    for (int n = 0; n < 25; n++) begin
      px(0, 0);
      px(700, 300);
    end
    px(100, 300);
    chk("bar_100", rgb, 24'hFFFFFF);
    px(700, 300);
    #2 sys_resetn = 1'b0;
    #1;
    chk("async_rgb", rgb, 24'h0);
    chk("async_fc", {16'h0, frame_count}, 24'h0);
    chk("async_fs", {23'h0, frame_start}, 24'h0);
    @(negedge clk_pixel);
    sys_resetn = 1'b1;
    px(700, 300);
    chk("post_reset_mode0", rgb, 24'hFF0000);
    px(0, 0);
    chk("post_reset_bar0", rgb, 24'hFFFFFF);
    px(3, 1);
    chk("post_reset_bar4_lo", rgb, 24'h0000FF);
    px(4, 1);
    chk("post_reset_bar4", rgb, 24'hFFFFFF);

    @(negedge clk_pixel);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
